// File: rtl/maria_regfile_gen2.sv
// MARIA register bank, second generation: palette decode, line-latched control,
// frame-committed DLL pointer with DMA handshake and the WSYNC ready state machine.
module maria_regfile_gen2 #(
  parameter int         NUM_PALETTES  = 8,
  parameter logic [7:0] BASE_ADDR     = 8'h20,
  parameter logic [7:0] OPEN_BUS      = 8'hBE,
  parameter bit         LATCH_AT_LINE = 1'b1
) (
  input  logic                         sysclock,
  input  logic                         reset,
  input  logic                         pclk0,
  input  logic                         sel,
  input  logic [7:0]                   addr,
  input  logic                         we_b,
  input  logic [7:0]                   db_in,
  output logic [7:0]                   db_out,
  input  logic [7:0]                   status_read,
  input  logic                         line_start,
  input  logic                         frame_start,
  output logic                         ready,
  output logic [7:0]                   bg_color,
  output logic [NUM_PALETTES*24-1:0]   palettes,
  output logic [7:0]                   char_base,
  output logic [7:0]                   ctrl,
  output logic [15:0]                  zp,
  output logic                         zp_valid,
  input  logic                         zp_ack
);

  localparam logic [7:0] SPAN_LIM = 8'(4 * NUM_PALETTES);

  typedef enum logic {ST_RUN, ST_WAIT} wsync_state_e;

  logic [7:0] w_off;
  logic       w_in_range;
  logic       w_wr;
  logic       w_rd;
  logic [5:0] w_slot;
  logic [1:0] w_entry;
  logic       w_wr_special;
  logic       w_wr_bg;
  logic       w_wr_wsync;
  logic       w_wr_zph;
  logic       w_wr_zpl;
  logic       w_wr_cbase;
  logic       w_wr_ctrl;

  assign w_off        = addr - BASE_ADDR;
  assign w_in_range   = (w_off < SPAN_LIM);
  assign w_wr         = sel & ~we_b & pclk0 & w_in_range;
  assign w_rd         = sel & we_b & pclk0;
  assign w_slot       = w_off[7:2];
  assign w_entry      = w_off[1:0];
  assign w_wr_special = w_wr & (w_entry == 2'd0);
  assign w_wr_bg      = w_wr_special & (w_slot == 6'd0);
  assign w_wr_wsync   = w_wr_special & (w_slot == 6'd1);
  assign w_wr_zph     = w_wr_special & (w_slot == 6'd3);
  assign w_wr_zpl     = w_wr_special & (w_slot == 6'd4);
  assign w_wr_cbase   = w_wr_special & (w_slot == 6'd5);
  assign w_wr_ctrl    = w_wr_special & (w_slot == 6'd7);

  // Colour storage: entry e (0..2) of palette p maps to offset 4p+e+1.
  logic [7:0] r_col [NUM_PALETTES][3];

  // NOTE: the colour array is a bank of flops, not a RAM, so it is safe (and required) to reset it.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PALETTES; p++)
        for (int e = 0; e < 3; e++)
          r_col[p][e] <= '0;
    end else if (w_wr && w_entry != 2'd0) begin
      for (int p = 0; p < NUM_PALETTES; p++)
        for (int e = 0; e < 3; e++)
          if (w_slot == 6'(p) && w_entry == 2'(e + 1))
            r_col[p][e] <= db_in;
    end
  end

  for (genvar gp = 0; gp < NUM_PALETTES; gp++) begin : g_pal
    for (genvar ge = 0; ge < 3; ge++) begin : g_ent
      assign palettes[(gp*3+ge)*8 +: 8] = r_col[gp][ge];
    end
  end

  logic [7:0] r_bg;
  logic [7:0] r_cbase;

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      r_bg    <= '0;
      r_cbase <= '0;
    end else begin
      if (w_wr_bg)    r_bg    <= db_in;
      if (w_wr_cbase) r_cbase <= db_in;
    end
  end

  assign bg_color  = r_bg;
  assign char_base = r_cbase;

  // A write landing on the same edge as line_start wins over the old shadow.
  logic [7:0] r_ctrl;
  logic [7:0] r_shadow;

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      r_ctrl   <= 8'h40;
      r_shadow <= 8'h40;
    end else begin
      if (w_wr_ctrl) r_shadow <= db_in;
      if (LATCH_AT_LINE) begin
        if (line_start) r_ctrl <= w_wr_ctrl ? db_in : r_shadow;
      end else if (w_wr_ctrl) begin
        r_ctrl <= db_in;
      end
    end
  end

  assign ctrl = r_ctrl;

  logic [7:0]  r_zph;
  logic [7:0]  r_zpl;
  logic [1:0]  r_pend;
  logic [15:0] r_zp;
  logic        r_zp_valid;
  logic [7:0]  w_zph_nxt;
  logic [7:0]  w_zpl_nxt;
  logic [1:0]  w_pend_nxt;
  logic        w_commit;

  // Staged bytes written on the frame_start edge still make it into that commit.
  assign w_zph_nxt  = w_wr_zph ? db_in : r_zph;
  assign w_zpl_nxt  = w_wr_zpl ? db_in : r_zpl;
  assign w_pend_nxt = r_pend | {w_wr_zph, w_wr_zpl};
  assign w_commit   = frame_start & (&w_pend_nxt);

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      r_zph      <= 8'h18;
      r_zpl      <= 8'h20;
      r_pend     <= 2'b00;
      r_zp       <= 16'h1820;
      r_zp_valid <= 1'b0;
    end else begin
      r_zph <= w_zph_nxt;
      r_zpl <= w_zpl_nxt;
      if (w_commit) begin
        r_zp       <= {w_zph_nxt, w_zpl_nxt};
        r_pend     <= 2'b00;
        r_zp_valid <= 1'b1;
      end else begin
        r_pend <= w_pend_nxt;
        if (zp_ack) r_zp_valid <= 1'b0;
      end
    end
  end

  assign zp       = r_zp;
  assign zp_valid = r_zp_valid;

  wsync_state_e r_state;
  logic         r_ready;

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN: if (w_wr_wsync) begin
          r_state <= ST_WAIT;
          r_ready <= 1'b0;
        end
        ST_WAIT: if (!w_wr_wsync && line_start) begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready = r_ready;

  logic [7:0] w_rd_data;

  // NOTE: w_rd_data gets a default before any branch so no latch is inferred.
  always_comb begin
    w_rd_data = OPEN_BUS;
    if (w_in_range) begin
      if (w_entry != 2'd0) begin
        for (int p = 0; p < NUM_PALETTES; p++)
          for (int e = 0; e < 3; e++)
            if (w_slot == 6'(p) && w_entry == 2'(e + 1))
              w_rd_data = r_col[p][e];
      end else begin
        case (w_slot)
          6'd0:    w_rd_data = r_bg;
          6'd2:    w_rd_data = status_read;
          6'd3:    w_rd_data = r_zph;
          6'd4:    w_rd_data = r_zpl;
          6'd5:    w_rd_data = r_cbase;
          6'd7:    w_rd_data = r_shadow;
          default: w_rd_data = OPEN_BUS;
        endcase
      end
    end
  end

  logic [7:0] r_db_out;

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset)     r_db_out <= OPEN_BUS;
    else if (w_rd) r_db_out <= w_rd_data;
  end

  assign db_out = r_db_out;

endmodule

// File: tb/tb_maria_regfile_gen2.sv
// Randomised bench for maria_regfile_gen2: three configurations driven in parallel
// against an offset-addressed behavioural model, plus the directed scenarios.
module tb_maria_regfile_gen2;

  logic       sysclock = 1'b0;
  logic       reset, pclk0, sel, we_b, line_start, frame_start, zp_ack;
  logic [7:0] addr, db_in, status_read;

  logic [7:0]   db_a, bg_a, cb_a, ctrl_a;
  logic [191:0] pal_a;
  logic [15:0]  zp_a;
  logic         ready_a, zv_a;
  logic [7:0]   db_b, bg_b, cb_b, ctrl_b;
  logic [191:0] pal_b;
  logic [15:0]  zp_b;
  logic         ready_b, zv_b;
  logic [7:0]   db_c, bg_c, cb_c, ctrl_c;
  logic [95:0]  pal_c;
  logic [15:0]  zp_c;
  logic         ready_c, zv_c;

  maria_regfile_gen2 #(.NUM_PALETTES(8), .LATCH_AT_LINE(1'b1)) dut_a (
    .sysclock(sysclock), .reset(reset), .pclk0(pclk0), .sel(sel), .addr(addr),
    .we_b(we_b), .db_in(db_in), .db_out(db_a), .status_read(status_read),
    .line_start(line_start), .frame_start(frame_start), .ready(ready_a),
    .bg_color(bg_a), .palettes(pal_a), .char_base(cb_a), .ctrl(ctrl_a),
    .zp(zp_a), .zp_valid(zv_a), .zp_ack(zp_ack));

  maria_regfile_gen2 #(.NUM_PALETTES(8), .LATCH_AT_LINE(1'b0)) dut_b (
    .sysclock(sysclock), .reset(reset), .pclk0(pclk0), .sel(sel), .addr(addr),
    .we_b(we_b), .db_in(db_in), .db_out(db_b), .status_read(status_read),
    .line_start(line_start), .frame_start(frame_start), .ready(ready_b),
    .bg_color(bg_b), .palettes(pal_b), .char_base(cb_b), .ctrl(ctrl_b),
    .zp(zp_b), .zp_valid(zv_b), .zp_ack(zp_ack));

  maria_regfile_gen2 #(.NUM_PALETTES(4), .LATCH_AT_LINE(1'b1)) dut_c (
    .sysclock(sysclock), .reset(reset), .pclk0(pclk0), .sel(sel), .addr(addr),
    .we_b(we_b), .db_in(db_in), .db_out(db_c), .status_read(status_read),
    .line_start(line_start), .frame_start(frame_start), .ready(ready_c),
    .bg_color(bg_c), .palettes(pal_c), .char_base(cb_c), .ctrl(ctrl_c),
    .zp(zp_c), .zp_valid(zv_c), .zp_ack(zp_ack));

  always #5 sysclock = ~sysclock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: byte-per-offset storage plus the few stateful registers.
  int         cfg_n     [3] = '{8, 8, 4};
  bit         cfg_latch [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] m_mem  [3][64];
  logic [7:0] m_shadow [3], m_ctrl [3], m_zph [3], m_zpl [3], m_db [3];
  logic       m_ph [3], m_pl [3], m_zv [3], m_wait [3];
  logic [15:0] m_zp [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) m_mem[k][i] = 8'h00;
      m_shadow[k] = 8'h40; m_ctrl[k] = 8'h40;
      m_zph[k] = 8'h18; m_zpl[k] = 8'h20; m_ph[k] = 0; m_pl[k] = 0;
      m_zp[k] = 16'h1820; m_zv[k] = 0; m_wait[k] = 0; m_db[k] = 8'hBE;
    end
  endtask

  function automatic logic [7:0] read_val(int k, int o);
    if (o % 4 != 0) return m_mem[k][o];
    case (o)
      0:       return m_mem[k][0];
      8:       return status_read;
      12:      return m_zph[k];
      16:      return m_zpl[k];
      20:      return m_mem[k][20];
      28:      return m_shadow[k];
      default: return 8'hBE;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      logic [7:0] ob;
      int o;
      bit inr, wr, rd, ctrl_wr;
      ob = addr - 8'h20;
      o = int'(ob);
      inr = (o < 4 * cfg_n[k]);
      wr = sel && !we_b && pclk0 && inr;
      rd = sel && we_b && pclk0;
      ctrl_wr = wr && (o == 28);
      if (rd) m_db[k] = inr ? read_val(k, o) : 8'hBE;
      if (wr && (o % 4 != 0 || o == 0 || o == 20)) m_mem[k][o] = db_in;
      if (wr && o == 12) begin m_zph[k] = db_in; m_ph[k] = 1; end
      if (wr && o == 16) begin m_zpl[k] = db_in; m_pl[k] = 1; end
      if (cfg_latch[k]) begin
        if (line_start) m_ctrl[k] = ctrl_wr ? db_in : m_shadow[k];
      end else if (ctrl_wr) m_ctrl[k] = db_in;
      if (ctrl_wr) m_shadow[k] = db_in;
      if (wr && o == 4) m_wait[k] = 1;
      else if (line_start) m_wait[k] = 0;
      if (frame_start && m_ph[k] && m_pl[k]) begin
        m_zp[k] = {m_zph[k], m_zpl[k]}; m_zv[k] = 1; m_ph[k] = 0; m_pl[k] = 0;
      end else if (zp_ack) m_zv[k] = 0;
    end
  endtask

  function automatic logic [191:0] exp_pal(int k);
    logic [191:0] v = '0;
    for (int p = 0; p < cfg_n[k]; p++)
      for (int e = 1; e <= 3; e++)
        v[(p*3+e-1)*8 +: 8] = m_mem[k][p*4+e];
    return v;
  endfunction

  task automatic cmp_dut(input int k, input logic rdy, input logic [7:0] db, input logic [7:0] bg,
                         input logic [191:0] pal, input logic [7:0] cb, input logic [7:0] ct,
                         input logic [15:0] z, input logic zv);
    check($sformatf("k%0d.ready", k), rdy, !m_wait[k]);
    check($sformatf("k%0d.db_out", k), db, m_db[k]);
    check($sformatf("k%0d.bg", k), bg, m_mem[k][0]);
    check($sformatf("k%0d.palettes", k), pal, exp_pal(k));
    check($sformatf("k%0d.char_base", k), cb, m_mem[k][20]);
    check($sformatf("k%0d.ctrl", k), ct, m_ctrl[k]);
    check($sformatf("k%0d.zp", k), z, m_zp[k]);
    check($sformatf("k%0d.zp_valid", k), zv, m_zv[k]);
  endtask

  task automatic cmp_all();
    cmp_dut(0, ready_a, db_a, bg_a, pal_a, cb_a, ctrl_a, zp_a, zv_a);
    cmp_dut(1, ready_b, db_b, bg_b, pal_b, cb_b, ctrl_b, zp_b, zv_b);
    cmp_dut(2, ready_c, db_c, bg_c, {96'b0, pal_c}, cb_c, ctrl_c, zp_c, zv_c);
  endtask

  task automatic tick();
    @(posedge sysclock);
    model_step();
    @(negedge sysclock);
    cmp_all();
  endtask

  task automatic set_idle();
    sel = 0; we_b = 1; pclk0 = 0; line_start = 0; frame_start = 0; zp_ack = 0;
    addr = 8'h00; db_in = 8'h00;
  endtask

  task automatic set_wr(input logic [7:0] a, input logic [7:0] d);
    sel = 1; we_b = 0; pclk0 = 1; addr = a; db_in = d;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    set_wr(a, d); tick(); set_idle();
  endtask

  task automatic rd(input logic [7:0] a);
    sel = 1; we_b = 1; pclk0 = 1; addr = a; tick(); set_idle();
  endtask

  logic [95:0] pal_c_save;

  initial begin
    set_idle();
    status_read = 8'h5A;
    reset = 1;
    model_reset();
    repeat (2) tick();
    reset = 0;
    tick();

    rd(8'h3C); check("rst_rd_ctrl", db_a, 8'h40);
    rd(8'h2C); check("rst_rd_zph", db_a, 8'h18);
    rd(8'h38); check("rd_unused", db_a, 8'hBE);
    rd(8'h28); check("rd_status", db_a, 8'h5A);

    wr(8'h21, 8'h55); wr(8'h3F, 8'hAA);
    check("pal0e1", pal_a[7:0], 8'h55);
    check("pal7e3", pal_a[191:184], 8'hAA);
    rd(8'h3F); check("rd_pal7e3", db_a, 8'hAA);

    wr(8'h24, 8'h00);
    check("wsync_low", ready_a, 1'b0);
    repeat (9) tick();
    check("wsync_still_low", ready_a, 1'b0);
    line_start = 1; tick(); set_idle();
    check("wsync_release", ready_a, 1'b1);

    set_wr(8'h24, 8'h00); line_start = 1; tick(); set_idle();
    check("wsync_coinc_low", ready_a, 1'b0);
    repeat (3) tick();
    check("wsync_coinc_hold", ready_a, 1'b0);
    line_start = 1; tick(); set_idle();
    check("wsync_coinc_rel", ready_a, 1'b1);

    wr(8'h3C, 8'h03);
    check("ctrl_latched_old", ctrl_a, 8'h40);
    check("ctrl_immediate", ctrl_b, 8'h03);
    rd(8'h3C); check("ctrl_shadow_rd", db_a, 8'h03);
    line_start = 1; tick(); set_idle();
    check("ctrl_at_line", ctrl_a, 8'h03);
    set_wr(8'h3C, 8'h07); line_start = 1; tick(); set_idle();
    check("ctrl_coinc", ctrl_a, 8'h07);

    wr(8'h2C, 8'h20);
    frame_start = 1; tick(); set_idle();
    check("zp_partial", zp_a, 16'h1820);
    check("zv_partial", zv_a, 1'b0);
    wr(8'h30, 8'h00);
    frame_start = 1; tick(); set_idle();
    check("zp_commit", zp_a, 16'h2000);
    check("zv_commit", zv_a, 1'b1);
    tick(); check("zv_hold", zv_a, 1'b1);
    wr(8'h2C, 8'h21); wr(8'h30, 8'h05);
    frame_start = 1; zp_ack = 1; tick(); set_idle();
    check("zp_ack_commit", zp_a, 16'h2105);
    check("zv_ack_commit", zv_a, 1'b1);
    zp_ack = 1; tick(); set_idle();
    check("zv_acked", zv_a, 1'b0);
    wr(8'h2C, 8'h30);
    set_wr(8'h30, 8'h44); frame_start = 1; tick(); set_idle();
    check("zp_coinc_wr", zp_a, 16'h3044);

    pal_c_save = pal_c;
    wr(8'h31, 8'h77);
    check("np4_oob_state", pal_c, pal_c_save);
    rd(8'h31); check("np4_oob_rd", db_c, 8'hBE);
    check("np8_o17_rd", db_a, 8'h77);

    wr(8'h24, 8'h00);
    check("wait_before_rst", ready_a, 1'b0);
    reset = 1;
    #1;
    model_reset();
    check("rst_ready_async", ready_a, 1'b1);
    check("rst_zp_async", zp_a, 16'h1820);
    tick();
    reset = 0;
    tick();

    for (int i = 0; i < 2000; i++) begin
      sel = ($urandom_range(0, 3) != 0);
      we_b = $urandom_range(0, 1);
      pclk0 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 85) addr = 8'h20 + 8'($urandom_range(0, 69));
      else addr = 8'($urandom);
      db_in = 8'($urandom);
      status_read = 8'($urandom);
      line_start = ($urandom_range(0, 19) == 0);
      frame_start = ($urandom_range(0, 29) == 0);
      zp_ack = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
      reset = 0;
    end
    set_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
